// File: rtl/mod_seq_pkg.sv
// mod_seq_pkg: shared state encoding, reset defaults and config legality check for the modulo-N sequencer
package mod_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;
  localparam int DEF_MOD = 100;
  localparam int DEF_PASSES = 1;
  function automatic logic cfg_ok(input int unsigned m, input int unsigned p, input logic cont, input int unsigned w);
    return (m >= 2) && (m <= (32'd1 << w)) && (cont || p != 0);
  endfunction
endpackage

// File: rtl/mod_n_counter.sv
// mod_n_counter: counts 0..modulus-1 while enabled, tc flags the wrapping cycle
module mod_n_counter #(
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W:0]   modulus,
  output logic [CNT_W-1:0] count,
  output logic             tc
);
  assign tc = ({1'b0, count} == modulus - (CNT_W+1)'(1)) & en;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (clr) count <= '0;
    else if (en) count <= tc ? '0 : count + CNT_W'(1);
endmodule

// File: rtl/mod_counter_sequencer.sv
// mod_counter_sequencer: configures and runs a modulo-N counter for a set number of wraps or forever,
// with pause/abort control and wrap/done/cfg_err pulses
module mod_counter_sequencer #(
  parameter int CNT_W   = 7,
  parameter int DEF_MOD = mod_seq_pkg::DEF_MOD,
  parameter int PASS_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CNT_W:0]    cfg_mod,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              cfg_cont,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  output logic [CNT_W-1:0]  count,
  output logic              wrap,
  output logic              done,
  output logic              busy,
  output logic [PASS_W-1:0] pass_cnt,
  output logic              cfg_err
);
  import mod_seq_pkg::*;
  state_t st, nxt;
  logic [CNT_W:0] act_mod;
  logic [PASS_W-1:0] act_passes;
  logic act_cont, hs, ok, bad_hs, go, en, clr, tc, fin;
  assign cfg_ready = st == IDLE;
  assign busy = st != IDLE;
  assign hs = cfg_valid & cfg_ready;
  assign ok = cfg_ok(32'(cfg_mod), 32'(cfg_passes), cfg_cont, CNT_W);
  assign bad_hs = hs & ~ok;
  // a rejected config in the same cycle cancels the start
  assign go = (st == IDLE) & start & ~bad_hs;
  assign en = (st == RUN) & ~abort & ~pause;
  assign clr = go | (busy & abort);
  assign fin = ~act_cont & (pass_cnt + PASS_W'(1) == act_passes);
  mod_n_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .modulus(act_mod), .count(count), .tc(tc)
  );
  always_comb begin
    nxt = st;
    nxt = (st == IDLE) ? (go ? RUN : IDLE)
        : abort ? IDLE
        : (st == PAUSED) ? (pause ? PAUSED : RUN)
        : pause ? PAUSED
        : (tc & fin) ? IDLE : RUN;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= IDLE;
      act_mod <= (CNT_W+1)'(DEF_MOD);
      act_passes <= PASS_W'(DEF_PASSES);
      act_cont <= 1'b0;
      pass_cnt <= '0;
      wrap <= 1'b0;
      done <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      st <= nxt;
      if (hs & ok) begin
        act_mod <= cfg_mod;
        act_passes <= cfg_passes;
        act_cont <= cfg_cont;
      end
      pass_cnt <= clr ? '0 : tc ? pass_cnt + PASS_W'(1) : pass_cnt;
      wrap <= tc;
      done <= tc & fin;
      cfg_err <= bad_hs;
    end
endmodule

// File: tb/tb_mod_counter_sequencer.sv
// tb_mod_counter_sequencer: directed and random stimulus against a behavioural model, scoreboard-checked
module tb_mod_counter_sequencer;
  logic clk = 0, rst = 1, cfg_valid = 0, cfg_cont = 0, start = 0, pause = 0, abort = 0;
  logic [7:0] cfg_mod = 0, cfg_passes = 0;
  logic [6:0] count;
  logic [7:0] pass_cnt;
  logic wrap, done, busy, cfg_ready, cfg_err;
  typedef struct packed {logic [6:0] cnt; logic [7:0] pc; logic w, d, b, r, e;} obs_t;
  obs_t exp_q[$];
  int n_chk = 0, n_fail = 0;
  int m_mod, m_pas, m_cnt, m_pc;
  bit m_cont, m_run, m_pau;

  mod_counter_sequencer dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_mod(cfg_mod),
    .cfg_passes(cfg_passes), .cfg_cont(cfg_cont), .start(start), .pause(pause), .abort(abort),
    .count(count), .wrap(wrap), .done(done), .busy(busy), .pass_cnt(pass_cnt), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  function automatic obs_t snap(bit w, bit d, bit e);
    return {7'(m_cnt), 8'(m_pc), w, d, m_run, !m_run, e};
  endfunction

  task automatic mreset();
    m_mod = 100; m_pas = 1; m_cont = 0; m_run = 0; m_pau = 0; m_cnt = 0; m_pc = 0;
  endtask

  // advance the model by one clock edge using the inputs currently driven
  task automatic step();
    bit w = 0, d = 0, e = 0, ok;
    if (!rst) begin
      mreset();
      exp_q.push_back(snap(0, 0, 0));
      return;
    end
    if (!m_run) begin
      ok = cfg_mod >= 2 && cfg_mod <= 128 && (cfg_cont || cfg_passes != 0);
      e = cfg_valid && !ok;
      if (cfg_valid && ok) begin m_mod = cfg_mod; m_pas = cfg_passes; m_cont = cfg_cont; end
      if (start && !e) begin m_run = 1; m_pau = 0; m_cnt = 0; m_pc = 0; end
    end else if (abort) begin
      m_run = 0; m_pau = 0; m_cnt = 0; m_pc = 0;
    end else if (m_pau) begin
      m_pau = pause;
    end else if (pause) begin
      m_pau = 1;
    end else if (m_cnt == m_mod - 1) begin
      m_cnt = 0; w = 1; m_pc = (m_pc + 1) % 256;
      if (!m_cont && m_pc == m_pas) begin d = 1; m_run = 0; end
    end else begin
      m_cnt++;
    end
    exp_q.push_back(snap(w, d, e));
  endtask

  task automatic cyc(input bit v = 0, input logic [7:0] m = 0, input logic [7:0] p = 0,
                     input bit c = 0, input bit s = 0, input bit pz = 0, input bit a = 0);
    cfg_valid = v; cfg_mod = m; cfg_passes = p; cfg_cont = c; start = s; pause = pz; abort = a;
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  // asserts reset between edges and checks the immediate clear
  task automatic do_reset();
    @(negedge clk);
    #1 rst = 0;
    #1;
    n_chk++;
    if ({count, pass_cnt, wrap, done, busy, cfg_ready, cfg_err} !== {7'd0, 8'd0, 5'b00010}) begin
      n_fail++;
      $display("FAIL async_reset: got cnt=%0d pc=%0d w=%b d=%b b=%b r=%b e=%b, want all zero with ready=1",
               count, pass_cnt, wrap, done, busy, cfg_ready, cfg_err);
    end
    mreset();
  endtask

  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {count, pass_cnt, wrap, done, busy, cfg_ready, cfg_err};
      n_chk++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got cnt=%0d pc=%0d w=%b d=%b b=%b r=%b e=%b, want cnt=%0d pc=%0d w=%b d=%b b=%b r=%b e=%b",
                 $time, a.cnt, a.pc, a.w, a.d, a.b, a.r, a.e, e.cnt, e.pc, e.w, e.d, e.b, e.r, e.e);
      end
    end
  end

  initial begin
    mreset();
    do_reset();
    repeat (2) cyc();
    rst = 1;
    // default N=100 one-shot run
    cyc(0, 0, 0, 0, 1);
    run(105);
    // N=10, three passes
    cyc(1, 10, 3, 0, 0);
    cyc(0, 0, 0, 0, 1);
    run(35);
    // illegal configs, including one that cancels a same-cycle start
    cyc(1, 1, 1, 0, 0);
    cyc(1, 129, 1, 0, 0);
    cyc(1, 5, 0, 0, 1);
    run(2);
    cyc(0, 0, 0, 0, 1);
    run(35);
    // legal config with start in the same cycle, then pause at 42
    cyc(1, 100, 1, 0, 1);
    run(42);
    repeat (4) cyc(0, 0, 0, 0, 0, 1);
    run(70);
    // abort together with pause at count 7
    cyc(0, 0, 0, 0, 1);
    run(7);
    cyc(0, 0, 0, 0, 0, 1, 1);
    run(3);
    // continuous N=4 across pass counter rollover, then reset mid-count
    cyc(1, 4, 0, 1, 1);
    run(1202);
    do_reset();
    repeat (2) cyc();
    rst = 1;
    cyc(0, 0, 0, 0, 1);
    run(103);
    // random traffic
    repeat (4000) begin
      if ($urandom_range(0, 1499) == 0) begin
        do_reset();
        cyc();
        rst = 1;
      end
      cyc($urandom_range(0, 3) == 0,
          ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(2, 12)),
          8'($urandom_range(0, 4)), $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 6) == 0, $urandom_range(0, 79) == 0);
    end
    run(3);
    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mod_counter_sequencer.md
Name: mod_counter_sequencer

Overview:
- Controller that configures, starts, pauses, aborts and counts passes of a programmable modulo-N counter (the mod-100 counter generalised to a runtime modulus).
- Accepts a configuration through a valid/ready handshake, then runs the counter for a fixed number of full wraps (one-shot) or forever (continuous).
- Sits between a host/test controller and the counter datapath; emits a per-wrap pulse and a completion pulse.

Parameters:
- CNT_W, 7, width of count output; legal moduli are 2..2**CNT_W.
- DEF_MOD, 100, modulus loaded at reset.
- PASS_W, 8, width of pass counter and cfg_passes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset: rst=0 resets immediately; release is synchronous to clk.
- cfg_valid  in  1  config offered.
- cfg_ready  out  1  config can be accepted; high only in IDLE.
- cfg_mod  in  CNT_W+1  modulus N.
- cfg_passes  in  PASS_W  wraps per run (one-shot mode).
- cfg_cont  in  1  1 = continuous mode.
- start  in  1  begin run (level sampled each clk).
- pause  in  1  freeze count while high.
- abort  in  1  terminate run.
- count  out  CNT_W  current count, 0..N-1.
- wrap  out  1  one-cycle pulse, registered.
- done  out  1  one-cycle pulse at end of one-shot run.
- busy  out  1  state is RUN or PAUSED.
- pass_cnt  out  PASS_W  wraps completed in current run.
- cfg_err  out  1  one-cycle pulse when a config is rejected.

Behaviour:
- Reset values: count=0, wrap=0, done=0, busy=0, pass_cnt=0, cfg_err=0, state=IDLE. Active config: N=DEF_MOD, passes=1, cont=0.
- States: IDLE, RUN, PAUSED.
- cfg_ready = (state==IDLE). A handshake occurs on cfg_valid & cfg_ready.
  - Legal config: 2 <= cfg_mod <= 2**CNT_W, and cfg_passes != 0 unless cfg_cont=1.
  - Illegal config: rejected, cfg_err pulses the next cycle, active config unchanged.
- IDLE:
  - start=1 -> RUN; count<=0, pass_cnt<=0.
  - If a legal handshake occurs in the same cycle, the run uses the new config.
  - If that handshake is illegal, the start is ignored and the state stays IDLE.
- RUN, evaluated each edge with priority abort > pause > count:
  - abort: -> IDLE, count<=0, pass_cnt<=0, no done, no wrap.
  - pause: -> PAUSED, count holds.
  - otherwise, if count < N-1: count<=count+1.
  - If count == N-1: count<=0, wrap<=1, pass_cnt<=pass_cnt+1 (mod 2**PASS_W).
    - One-shot and pass_cnt+1 == passes: done<=1, -> IDLE.
    - Continuous: never completes.
- PAUSED:
  - abort -> IDLE, with the same clears as abort in RUN.
  - pause=0 -> RUN; counting resumes the following edge, with no count skipped or repeated.
- start is ignored outside IDLE. cfg_valid is ignored outside IDLE.
- Latency: start sampled at edge k gives count=0 and busy=1 after edge k. Count reaches N-1 after edge k+N-1. The wrap pulse and count=0 follow edge k+N.
- The final wrap and done assert in the same cycle; busy=0 in that same cycle.
- Asynchronous reset mid-run: everything returns to reset values including the active config; the run is lost, with no done.
- wrap and done are never asserted while rst=0.

Decomposition:
- Package mod_seq_pkg holds:
  - the state enum (IDLE, RUN, PAUSED);
  - the defaults DEF_MOD and DEF_PASSES=1;
  - a function that checks config legality.
- One sub-module, mod_n_counter:
  - inputs: clk, rst, en, clr, modulus; outputs: count, tc.
  - tc is combinational: (count == modulus-1) & en.
  - The sequencer drives en = (state==RUN & ~abort & ~pause) and clr on start or abort.

Test Plan:
- Reset default run: reset, start pulse -> count steps 0..99, wrap and done pulse together 100 cycles after the start edge, pass_cnt=1, busy drops.
- Config cfg_mod=10, cfg_passes=3, cfg_cont=0, then start -> three wrap pulses spaced 10 cycles apart, done with the third, pass_cnt=3, total 30 cycles busy.
- Illegal config cfg_mod=1 (then cfg_mod=129 with CNT_W=7) -> cfg_err pulse; a following start runs with the previous N; cfg_passes=0 with cfg_cont=0 also gives cfg_err.
- Pause for 5 cycles at count=42 with N=100 -> count holds at 42 for 5 cycles, resumes at 43, done is delayed by exactly 5 cycles.
- Abort at count=7, with pause asserted in the same cycle -> IDLE, count=0, no wrap or done; cfg_ready=1 the next cycle.
- Continuous N=4: run 300 wraps -> pass_cnt wraps 255 to 0, done never asserts. Asserting rst=0 mid-count clears all outputs immediately, and the active config returns to N=100.
